// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers for the twiddle multiply stage that follows
// the stride-2 radix-2 butterfly.
//   TW_WIDTH / TW_FRAC : twiddle format, signed Q1.8 (256 = 1.0)
//   TW_COS / TW_NSIN   : W_64^k = (cos, -sin), both scaled by 256 and rounded
//   cplx_t             : one signed complex sample at the butterfly width
//   lane_exp()         : twiddle exponent for a lane within a block
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int TW_WIDTH = 10;
  localparam int TW_FRAC  = 8;
  localparam int SAMPLE_W = 14;
  localparam int TW_N     = 64;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  // round(256*cos(2*pi*k/64)), k = 0..63
  localparam int TW_COS [TW_N] = '{
     256,  255,  251,  245,  237,  226,  213,  198,
     181,  162,  142,  121,   98,   74,   50,   25,
       0,  -25,  -50,  -74,  -98, -121, -142, -162,
    -181, -198, -213, -226, -237, -245, -251, -255,
    -256, -255, -251, -245, -237, -226, -213, -198,
    -181, -162, -142, -121,  -98,  -74,  -50,  -25,
       0,   25,   50,   74,   98,  121,  142,  162,
     181,  198,  213,  226,  237,  245,  251,  255
  };

  // -round(256*sin(2*pi*k/64)), k = 0..63
  localparam int TW_NSIN [TW_N] = '{
       0,  -25,  -50,  -74,  -98, -121, -142, -162,
    -181, -198, -213, -226, -237, -245, -251, -255,
    -256, -255, -251, -245, -237, -226, -213, -198,
    -181, -162, -142, -121,  -98,  -74,  -50,  -25,
       0,   25,   50,   74,   98,  121,  142,  162,
     181,  198,  213,  226,  237,  245,  251,  255,
     256,  255,  251,  245,  237,  226,  213,  198,
     181,  162,  142,  121,   98,   74,   50,   25
  };

  // Lanes 0,1 of every group of four are bypass lanes (k = 0); lanes 2,3
  // take k = 4*b + (lane mod 2), wrapped to the table size.
  function automatic logic [5:0] lane_exp(input int unsigned lane,
                                          input int unsigned blk);
    logic [5:0] k;
    k = '0;
    if ((lane % 4) >= 2) k = 6'((4 * blk + (lane % 2)) % TW_N);
    return k;
  endfunction

endpackage

// File: rtl/cmul_rnd_sat.sv
// ---------------------------------------------------------------------------
// cmul_rnd_sat
// Two-stage pipelined complex multiply (a_re + j a_im) * (c + j d) with
// round-half-up to the twiddle fraction and saturation to O_WIDTH.
//   clk, rstn          : clock, async active-low reset
//   i_s1_valid         : operands valid, load product stage
//   i_s2_valid         : products valid, load output stage
//   i_a_re, i_a_im     : sample
//   i_c, i_d           : twiddle (Q1.8)
//   o_re, o_im         : rounded, saturated result (held when not loaded)
//   o_sat              : result of the last loaded block clipped (0 otherwise)
// ---------------------------------------------------------------------------
module cmul_rnd_sat #(
  parameter int I_WIDTH  = 14,
  parameter int O_WIDTH  = 14,
  parameter int TW_WIDTH = fft_pkg::TW_WIDTH,
  parameter int FRAC     = fft_pkg::TW_FRAC
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_s1_valid,
  input  logic                       i_s2_valid,
  input  logic signed [I_WIDTH-1:0]  i_a_re,
  input  logic signed [I_WIDTH-1:0]  i_a_im,
  input  logic signed [TW_WIDTH-1:0] i_c,
  input  logic signed [TW_WIDTH-1:0] i_d,
  output logic signed [O_WIDTH-1:0]  o_re,
  output logic signed [O_WIDTH-1:0]  o_im,
  output logic                       o_sat
);

  localparam int PW = I_WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] RND   = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (O_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = SW'(-(1 << (O_WIDTH - 1)));

  function automatic logic [O_WIDTH:0] clip(input logic signed [SW-1:0] x);
    if (x > S_MAX)      return {1'b1, O_WIDTH'(S_MAX)};
    else if (x < S_MIN) return {1'b1, O_WIDTH'(S_MIN)};
    else                return {1'b0, O_WIDTH'(x)};
  endfunction

  logic signed [PW-1:0]      r_ac, r_bd, r_ad, r_bc;
  logic signed [SW-1:0]      w_re_sum, w_im_sum, w_re_sh, w_im_sh;
  logic signed [O_WIDTH-1:0] w_re_o, w_im_o;
  logic                      w_re_sat, w_im_sat;
  logic signed [O_WIDTH-1:0] r_re, r_im;
  logic                      r_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ac <= '0;
      r_bd <= '0;
      r_ad <= '0;
      r_bc <= '0;
    end else if (i_s1_valid) begin
      r_ac <= PW'(i_a_re) * PW'(i_c);
      r_bd <= PW'(i_a_im) * PW'(i_d);
      r_ad <= PW'(i_a_re) * PW'(i_d);
      r_bc <= PW'(i_a_im) * PW'(i_c);
    end
  end

  always_comb begin
    w_re_sum = SW'(r_ac) - SW'(r_bd);
    w_im_sum = SW'(r_ad) + SW'(r_bc);
    w_re_sh  = (w_re_sum + RND) >>> FRAC;
    w_im_sh  = (w_im_sum + RND) >>> FRAC;
    {w_re_sat, w_re_o} = clip(w_re_sh);
    {w_im_sat, w_im_o} = clip(w_im_sh);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_re  <= '0;
      r_im  <= '0;
      r_sat <= 1'b0;
    end else begin
      r_sat <= i_s2_valid & (w_re_sat | w_im_sat);
      if (i_s2_valid) begin
        r_re <= w_re_o;
        r_im <= w_im_o;
      end
    end
  end

  assign o_re  = r_re;
  assign o_im  = r_im;
  assign o_sat = r_sat;

endmodule

// File: rtl/twiddle_mul_stage.sv
// ---------------------------------------------------------------------------
// twiddle_mul_stage
// Streams 16-lane complex blocks from the radix-2 butterfly, multiplies each
// lane by W_64^k (k from lane and block index), rounds and saturates back to
// O_WIDTH. Three-cycle latency, one block per clock, no backpressure.
//   clk, rstn          : clock, async active-low reset
//   din_valid          : din_re/din_im carry a block this cycle
//   frame_start        : with din_valid, this block is block 0 of a frame
//   din_re, din_im     : lane i at [i*I_WIDTH +: I_WIDTH]
//   dout_valid         : dout_re/dout_im carry a block
//   dout_last          : valid output block is the last of its frame
//   dout_re, dout_im   : lane i at [i*O_WIDTH +: O_WIDTH], held between blocks
//   sat_pulse          : any lane of the current output block saturated
// ---------------------------------------------------------------------------
module twiddle_mul_stage
  import fft_pkg::*;
#(
  parameter int I_WIDTH    = 14,
  parameter int O_WIDTH    = 14,
  parameter int TW_WIDTH   = fft_pkg::TW_WIDTH,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BLK    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  input  logic                          frame_start,
  input  logic [DATA_WIDTH*I_WIDTH-1:0] din_re,
  input  logic [DATA_WIDTH*I_WIDTH-1:0] din_im,
  output logic                          dout_valid,
  output logic                          dout_last,
  output logic [DATA_WIDTH*O_WIDTH-1:0] dout_re,
  output logic [DATA_WIDTH*O_WIDTH-1:0] dout_im,
  output logic                          sat_pulse
);

  localparam int BW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLK - 1);

  logic [BW-1:0] r_blk;
  logic [BW-1:0] w_b;
  logic [BW-1:0] w_blk_nxt;

  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic r_s1_last,  r_s2_last,  r_s3_last;

  logic signed [I_WIDTH-1:0] r_s1_re [DATA_WIDTH];
  logic signed [I_WIDTH-1:0] r_s1_im [DATA_WIDTH];

  logic [DATA_WIDTH-1:0] w_sat_vec;

  // Block index for the incoming block; frame_start restarts the frame.
  always_comb begin
    w_b       = frame_start ? '0 : r_blk;
    w_blk_nxt = (w_b == LAST_BLK) ? '0 : w_b + 1'b1;
  end

  // Control pipeline: valid and last-of-frame travel alongside the data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_blk      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_last  <= 1'b0;
    end else begin
      if (din_valid) r_blk <= w_blk_nxt;
      r_s1_valid <= din_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      r_s1_last  <= din_valid  & (w_b == LAST_BLK);
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s3_last  <= r_s2_valid & r_s2_last;
    end
  end

  // S1 sample capture for all lanes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        r_s1_re[l] <= '0;
        r_s1_im[l] <= '0;
      end
    end else if (din_valid) begin
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        r_s1_re[l] <= din_re[l*I_WIDTH +: I_WIDTH];
        r_s1_im[l] <= din_im[l*I_WIDTH +: I_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    logic signed [O_WIDTH-1:0] w_re;
    logic signed [O_WIDTH-1:0] w_im;

    if ((i % 4) >= 2) begin : g_mul
      logic [5:0]                w_k;
      logic signed [TW_WIDTH-1:0] r_c;
      logic signed [TW_WIDTH-1:0] r_d;

      assign w_k = lane_exp(i, 32'(w_b));

      // S1 twiddle lookup, registered next to the captured sample.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_c <= '0;
          r_d <= '0;
        end else if (din_valid) begin
          r_c <= TW_WIDTH'(TW_COS[w_k]);
          r_d <= TW_WIDTH'(TW_NSIN[w_k]);
        end
      end

      cmul_rnd_sat #(
        .I_WIDTH  (I_WIDTH),
        .O_WIDTH  (O_WIDTH),
        .TW_WIDTH (TW_WIDTH),
        .FRAC     (TW_FRAC)
      ) u_cmul (
        .clk        (clk),
        .rstn       (rstn),
        .i_s1_valid (r_s1_valid),
        .i_s2_valid (r_s2_valid),
        .i_a_re     (r_s1_re[i]),
        .i_a_im     (r_s1_im[i]),
        .i_c        (r_c),
        .i_d        (r_d),
        .o_re       (w_re),
        .o_im       (w_im),
        .o_sat      (w_sat_vec[i])
      );
    end else begin : g_byp
      // k = 0: the multiply is the identity, so only the delay is kept.
      logic signed [I_WIDTH-1:0] r_re2, r_im2;
      logic signed [O_WIDTH-1:0] r_re3, r_im3;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_re2 <= '0;
          r_im2 <= '0;
          r_re3 <= '0;
          r_im3 <= '0;
        end else begin
          if (r_s1_valid) begin
            r_re2 <= r_s1_re[i];
            r_im2 <= r_s1_im[i];
          end
          if (r_s2_valid) begin
            r_re3 <= O_WIDTH'(r_re2);
            r_im3 <= O_WIDTH'(r_im2);
          end
        end
      end

      assign w_re         = r_re3;
      assign w_im         = r_im3;
      assign w_sat_vec[i] = 1'b0;
    end

    assign dout_re[i*O_WIDTH +: O_WIDTH] = w_re;
    assign dout_im[i*O_WIDTH +: O_WIDTH] = w_im;
  end

  assign dout_valid = r_s3_valid;
  assign dout_last  = r_s3_last;
  assign sat_pulse  = |w_sat_vec;

endmodule

// File: tb/tb_twiddle_mul_stage.sv
module tb_twiddle_mul_stage;

  localparam int IW = 14;
  localparam int OW = 14;
  localparam int DW = 16;

  logic              clk;
  logic              rstn;
  logic              din_valid;
  logic              frame_start;
  logic [DW*IW-1:0]  din_re;
  logic [DW*IW-1:0]  din_im;
  logic              dout_valid;
  logic              dout_last;
  logic [DW*OW-1:0]  dout_re;
  logic [DW*OW-1:0]  dout_im;
  logic              sat_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  twiddle_mul_stage #(
    .I_WIDTH    (IW),
    .O_WIDTH    (OW),
    .TW_WIDTH   (10),
    .DATA_WIDTH (DW),
    .NUM_BLK    (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .din_re      (din_re),
    .din_im      (din_im),
    .dout_valid  (dout_valid),
    .dout_last   (dout_last),
    .dout_re     (dout_re),
    .dout_im     (dout_im),
    .sat_pulse   (sat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_data();
    din_re = '0;
    din_im = '0;
  endtask

  task automatic set_lane(input int l, input int re, input int im);
    din_re[l*IW +: IW] = IW'(re);
    din_im[l*IW +: IW] = IW'(im);
  endtask

  function automatic int out_re(input int l);
    logic signed [OW-1:0] v;
    v = dout_re[l*OW +: OW];
    return int'(v);
  endfunction

  function automatic int out_im(input int l);
    logic signed [OW-1:0] v;
    v = dout_im[l*OW +: OW];
    return int'(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn        = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    clear_data();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_last",  int'(dout_last),  0);
    check("rst_sat",   int'(sat_pulse),  0);
    check("rst_re_zero", int'(dout_re == '0), 1);
    check("rst_im_zero", int'(dout_im == '0), 1);
    rstn = 1'b1;
    @(negedge clk);

    // Bypass lanes, 3-cycle latency
    clear_data();
    set_lane(0, 100, -37);
    set_lane(1, -8192, 8191);
    din_valid   = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    din_valid   = 1'b0;
    frame_start = 1'b0;
    clear_data();
    @(negedge clk);
    check("byp_not_early", int'(dout_valid), 0);
    @(negedge clk);
    check("byp_valid",  int'(dout_valid), 1);
    check("byp_l0_re",  out_re(0), 100);
    check("byp_l0_im",  out_im(0), -37);
    check("byp_l1_re",  out_re(1), -8192);
    check("byp_l1_im",  out_im(1), 8191);
    check("byp_sat",    int'(sat_pulse), 0);
    check("byp_last",   int'(dout_last), 0);
    @(negedge clk);
    check("byp_one_shot", int'(dout_valid), 0);

    // Twiddle -j on block 4 lane 2, k=17 on lane 3
    for (int t = 0; t < 8; t++) begin
      if (t >= 3) check("tw_valid", int'(dout_valid), 1);
      if (t == 7) begin
        check("tw_l2_re", out_re(2), 50);
        check("tw_l2_im", out_im(2), -100);
        check("tw_l3_re", out_re(3), -25);
        check("tw_l3_im", out_im(3), -255);
      end
      clear_data();
      if (t == 4) begin
        set_lane(2, 100, 50);
        set_lane(3, 256, 0);
      end
      din_valid   = (t < 5);
      frame_start = (t == 0);
      @(negedge clk);
    end

    // Saturation on block 2 lane 2
    for (int t = 0; t < 7; t++) begin
      if (t == 3 || t == 4) check("sat_pre", int'(sat_pulse), 0);
      if (t == 5) begin
        check("sat_valid", int'(dout_valid), 1);
        check("sat_pulse", int'(sat_pulse), 1);
        check("sat_l2_re", out_re(2), 0);
        check("sat_l2_im", out_im(2), -8192);
      end
      if (t == 6) begin
        check("sat_post_pulse", int'(sat_pulse), 0);
        check("sat_post_valid", int'(dout_valid), 0);
      end
      clear_data();
      if (t == 2) set_lane(2, 8191, -8191);
      din_valid   = (t < 3);
      frame_start = (t == 0);
      @(negedge clk);
    end

    // 20 consecutive blocks: wrap and last-of-frame
    for (int t = 0; t < 23; t++) begin
      if (t >= 3) begin
        check("wrap_valid", int'(dout_valid), 1);
        check("wrap_last",  int'(dout_last), (t - 2 == 16) ? 1 : 0);
      end
      if (t - 2 == 16) begin
        check("wrap_b15_l2_re", out_re(2), 73);
        check("wrap_b15_l2_im", out_im(2), 85);
      end
      if (t - 2 == 17) begin
        check("wrap_b0_l2_re", out_re(2), 100);
        check("wrap_b0_l2_im", out_im(2), 50);
      end
      clear_data();
      set_lane(2, 100, 50);
      din_valid   = (t < 20);
      frame_start = (t == 0);
      @(negedge clk);
    end

    // Gaps 1,0,0,1 with frame_start on the second valid block (first uses b=4)
    for (int t = 0; t < 7; t++) begin
      if (t >= 3)
        check("gap_valid", int'(dout_valid), (t == 3 || t == 6) ? 1 : 0);
      if (t == 3) begin
        check("gap_b4_l2_re", out_re(2), 50);
        check("gap_b4_l2_im", out_im(2), -100);
      end
      if (t == 6) begin
        check("gap_b0_l2_re", out_re(2), 100);
        check("gap_b0_l2_im", out_im(2), 50);
      end
      clear_data();
      set_lane(2, 100, 50);
      din_valid   = (t == 0 || t == 3);
      frame_start = (t == 3);
      @(negedge clk);
    end

    // Reset with two blocks in flight
    for (int t = 0; t < 2; t++) begin
      clear_data();
      set_lane(2, 100, 50);
      din_valid   = 1'b1;
      frame_start = (t == 0);
      @(negedge clk);
    end
    din_valid   = 1'b0;
    frame_start = 1'b0;
    check("pre_rst_re_nonzero", int'(dout_re != '0), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid",   int'(dout_valid), 0);
    check("mid_rst_re_zero", int'(dout_re == '0), 1);
    check("mid_rst_im_zero", int'(dout_im == '0), 1);
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      check("post_rst_idle", int'(dout_valid), 0);
      @(negedge clk);
    end
    clear_data();
    set_lane(2, 100, 50);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    clear_data();
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", int'(dout_valid), 1);
    check("post_rst_l2_re", out_re(2), 100);
    check("post_rst_l2_im", out_im(2), 50);
    check("post_rst_last",  int'(dout_last), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/twiddle_mul_stage.md
Name: twiddle_mul_stage

Overview:
- Downstream neighbour of the stride-2 radix-2 add/sub butterfly stage. Consumes its 16-lane, 14-bit signed complex output.
- Multiplies each lane by a per-lane, per-block twiddle factor W_64^k and rounds the result back to 14 bits with saturation.
- Fully pipelined streaming stage: one 16-lane block per clk, no backpressure.
- Adds the block-valid, block counter and frame tracking that the butterfly stage lacks.

Parameters:
- I_WIDTH, 14, input sample width (signed, per re/im).
- O_WIDTH, 14, output sample width (signed, per re/im).
- TW_WIDTH, 10, twiddle width, signed Q1.8 (256 = 1.0).
- DATA_WIDTH, 16, lanes per block.
- NUM_BLK, 16, blocks per frame; block counter wraps at NUM_BLK-1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- din_valid  in  1  din_re/din_im hold a valid block this cycle
- frame_start  in  1  qualified by din_valid; current block is block 0 of a new frame
- din_re  in  I_WIDTH x DATA_WIDTH  lane real parts
- din_im  in  I_WIDTH x DATA_WIDTH  lane imaginary parts
- dout_valid  out  1  dout holds a valid block
- dout_last  out  1  valid output block is block NUM_BLK-1 of its frame
- dout_re  out  O_WIDTH x DATA_WIDTH  lane real results
- dout_im  out  O_WIDTH x DATA_WIDTH  lane imaginary results
- sat_pulse  out  1  one-cycle pulse, aligned with dout_valid: any lane saturated in this block

Behaviour:
Reset:
- rstn low (async): dout_valid, dout_last and sat_pulse are 0; all dout lanes are 0; block counter blk is 0.
- All pipeline valid bits clear immediately, so in-flight blocks are discarded.
- The first valid output after release needs a fresh din_valid.

Block counter:
- blk has width clog2(NUM_BLK).
- On a cycle with din_valid=1, the block uses b = 0 if frame_start=1, else b = blk.
- Next blk = (b == NUM_BLK-1) ? 0 : b+1.
- din_valid=0 leaves blk unchanged; frame_start is ignored when din_valid=0.

Twiddle exponent for lane i, block b:
- i mod 4 in {0,1}: k = 0 (bypass).
- i mod 4 in {2,3}: k = (4*b + (i mod 2)) mod 64.
- W_64^k = (c, d) with c = round(256*cos(2πk/64)) and d = -round(256*sin(2πk/64)), from a 64-entry constant table.

Arithmetic:
- re = a*c - b*d, im = a*d + b*c, computed at full width (I_WIDTH+TW_WIDTH+1).
- Round half-up: add 128, arithmetic shift right 8.
- Saturate to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
- Bypass lanes (k=0) pass a, b through sign-extended, delay-matched. They never saturate when O_WIDTH ≥ I_WIDTH.

Pipeline, latency exactly 3 cycles from din_valid to dout_valid:
- S1: register inputs, b, lane exponents and twiddle lookup.
- S2: four real products per lane.
- S3: sum/difference, round, saturate, output register.

Output timing:
- dout_last = dout_valid and (block index == NUM_BLK-1).
- sat_pulse is the OR over all 32 re/im saturation flags of that block.
- dout_re/dout_im hold their last value when dout_valid=0. Verification checks dout only when dout_valid=1.

Other rules:
- Back-to-back valid blocks: throughput is 1 block/cycle, no bubbles.
- Gaps in din_valid propagate as gaps on dout_valid with the same spacing.

Decomposition:
- Package fft_pkg holds:
  - the TW_WIDTH constant;
  - the 64-entry twiddle cos/sin tables as localparam arrays;
  - typedef cplx_t (signed re/im);
  - a function for lane-exponent computation.
- Sub-module cmul_rnd_sat: one pipelined complex multiply with round/saturate and sat flag. It is instantiated once per lane via generate; bypass lanes use a matched-delay register chain instead.

Test Plan:
- Bypass lanes: frame_start+valid, lane0 = (100,-37), lane1 = (-8192,8191) -> 3 cycles later dout lane0 = (100,-37), lane1 = (-8192,8191), dout_valid=1, sat_pulse=0.
- Twiddle -j: send blocks b=0..4, block 4 lane2 = (100,50) -> k=16, W=(0,-256), dout lane2 = (50,-100) on the 5th valid output.
- Saturation: block b=2, lane2 = (8191,-8191), k=8, W=(181,-181) -> dout lane2 = (0,-8192), sat_pulse=1 for that cycle only.
- Wrap/last: 20 consecutive valid blocks, frame_start on the first only -> dout_last high on outputs 16 only; output 17 uses b=0 (lane2 k=0 passes through unchanged).
- Gaps and frame_start mid-frame: valid pattern 1,0,0,1 with frame_start on the 2nd valid -> dout_valid pattern 1,0,0,1 delayed by 3 cycles; the 2nd block uses b=0.
- Reset mid-operation: 2 blocks in flight, pull rstn low for 1 cycle -> all outputs 0 immediately; no dout_valid afterward until new din_valid; blk restarts at 0.
